// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants: module count, write ports, FIFO depth,
// the rd=0 "no write" tag, and a mod-5 wrap helper for the RR scan.
package wb_arbiter_pkg;

  localparam int NUM_MOD    = 5;
  localparam int NUM_WR     = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int RD_NONE    = 0;

  typedef logic [2:0] mod_idx_t;

  // v is at most 2*(NUM_MOD-1), so a single subtract wraps it.
  function automatic mod_idx_t mod_wrap(input logic [3:0] v);
    if (v >= 4'(NUM_MOD)) return mod_idx_t'(v - 4'(NUM_MOD));
    return mod_idx_t'(v);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry result FIFO for one execution module.
// Ports: i_push/i_pop/i_din in; o_full/o_empty/o_head out; i_flush empties.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int W = 37
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         rp_q, rp_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop, wp;

  assign o_full  = (cnt_q == 2'(FIFO_DEPTH));
  assign o_empty = (cnt_q == 2'd0);
  assign o_head  = mem_q[rp_q];

  assign do_push = i_push & ~o_full & ~i_flush;
  assign do_pop  = i_pop & ~o_empty;
  // Write slot is rp+cnt mod 2; never used when full.
  assign wp      = rp_q ^ cnt_q[0];

  always_comb begin
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    rp_d  = rp_q ^ do_pop;
    if (i_flush) begin
      cnt_d = '0;
      rp_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      rp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rp_q  <= rp_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wp] <= i_din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback collector: buffers results from modules 0-4 and grants
// them round-robin onto two register-file write ports; o_bypass = port-0 tag.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTH_REG = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid0,
  input  logic                 i_valid1,
  input  logic                 i_valid2,
  input  logic                 i_valid3,
  input  logic                 i_valid4,
  input  logic [WIDTH_REG-1:0] i_rd0,
  input  logic [WIDTH_REG-1:0] i_rd1,
  input  logic [WIDTH_REG-1:0] i_rd2,
  input  logic [WIDTH_REG-1:0] i_rd3,
  input  logic [WIDTH_REG-1:0] i_rd4,
  input  logic [WIDTH-1:0]     i_data0,
  input  logic [WIDTH-1:0]     i_data1,
  input  logic [WIDTH-1:0]     i_data2,
  input  logic [WIDTH-1:0]     i_data3,
  input  logic [WIDTH-1:0]     i_data4,
  output logic                 o_ready0,
  output logic                 o_ready1,
  output logic                 o_ready2,
  output logic                 o_ready3,
  output logic                 o_ready4,
  output logic                 o_we0,
  output logic                 o_we1,
  output logic [WIDTH_REG-1:0] o_waddr0,
  output logic [WIDTH_REG-1:0] o_waddr1,
  output logic [WIDTH-1:0]     o_wdata0,
  output logic [WIDTH-1:0]     o_wdata1,
  output logic [WIDTH_REG-1:0] o_bypass
);

  localparam int EW = WIDTH + WIDTH_REG;

  logic [NUM_MOD-1:0] valid, full, empty, pop;
  logic [EW-1:0]      din  [NUM_MOD];
  logic [EW-1:0]      head [NUM_MOD];

  assign valid   = {i_valid4, i_valid3, i_valid2,
                    i_valid1, i_valid0};
  assign din[0]  = {i_rd0, i_data0};
  assign din[1]  = {i_rd1, i_data1};
  assign din[2]  = {i_rd2, i_data2};
  assign din[3]  = {i_rd3, i_data3};
  assign din[4]  = {i_rd4, i_data4};

  assign o_ready0 = ~full[0];
  assign o_ready1 = ~full[1];
  assign o_ready2 = ~full[2];
  assign o_ready3 = ~full[3];
  assign o_ready4 = ~full[4];

  for (genvar m = 0; m < NUM_MOD; m++) begin : g_fifo
    wb_fifo #(.W(EW)) u_fifo (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_flush(i_flush),
      .i_push (valid[m]),
      .i_pop  (pop[m]),
      .i_din  (din[m]),
      .o_full (full[m]),
      .o_empty(empty[m]),
      .o_head (head[m])
    );
  end

  mod_idx_t          rr_q, rr_d, idx;
  mod_idx_t          gi [NUM_WR];
  logic [NUM_WR-1:0] gv;

  // First two non-empty FIFOs from rr onward; port 0 fills first.
  always_comb begin
    gv    = '0;
    gi[0] = '0;
    gi[1] = '0;
    idx   = '0;
    pop   = '0;
    for (int i = 0; i < NUM_MOD; i++) begin
      idx = mod_wrap(4'(rr_q) + 4'(i));
      if (!empty[idx]) begin
        if (!gv[0]) begin
          gv[0] = 1'b1;
          gi[0] = idx;
        end else if (!gv[1]) begin
          gv[1] = 1'b1;
          gi[1] = idx;
        end
      end
    end
    for (int k = 0; k < NUM_WR; k++)
      if (gv[k]) pop[gi[k]] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (i_flush)    rr_d = '0;
    else if (gv[1]) rr_d = mod_wrap(4'(gi[1]) + 4'd1);
    else if (gv[0]) rr_d = mod_wrap(4'(gi[0]) + 4'd1);
  end

  logic [EW-1:0]        hsel    [NUM_WR];
  logic [NUM_WR-1:0]    we_q, we_d;
  logic [WIDTH_REG-1:0] waddr_q [NUM_WR];
  logic [WIDTH_REG-1:0] waddr_d [NUM_WR];
  logic [WIDTH-1:0]     wdata_q [NUM_WR];
  logic [WIDTH-1:0]     wdata_d [NUM_WR];

  // rd=0 entries are granted and popped but never written.
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      hsel[k]    = head[gi[k]];
      we_d[k]    = gv[k] & ~i_flush &
                   (hsel[k][EW-1 -: WIDTH_REG] != WIDTH_REG'(RD_NONE));
      waddr_d[k] = waddr_q[k];
      wdata_d[k] = wdata_q[k];
      if (gv[k]) begin
        waddr_d[k] = hsel[k][EW-1 -: WIDTH_REG];
        wdata_d[k] = hsel[k][WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q <= '0;
      we_q <= '0;
      for (int k = 0; k < NUM_WR; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      for (int k = 0; k < NUM_WR; k++) begin
        waddr_q[k] <= waddr_d[k];
        wdata_q[k] <= wdata_d[k];
      end
    end
  end

  assign o_we0    = we_q[0];
  assign o_we1    = we_q[1];
  assign o_waddr0 = waddr_q[0];
  assign o_waddr1 = waddr_q[1];
  assign o_wdata0 = wdata_q[0];
  assign o_wdata1 = wdata_q[1];
  assign o_bypass = we_q[0] ? waddr_q[0] : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, fairness,
// backpressure, rd=0 drop, flush and asynchronous reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  valid;
  logic [4:0]  rd   [5];
  logic [31:0] data [5];
  logic [4:0]  rdy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1, byp;
  logic [31:0] wd0, wd1;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH(32), .WIDTH_REG(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid0(valid[0]), .i_valid1(valid[1]),
    .i_valid2(valid[2]), .i_valid3(valid[3]),
    .i_valid4(valid[4]),
    .i_rd0(rd[0]), .i_rd1(rd[1]), .i_rd2(rd[2]),
    .i_rd3(rd[3]), .i_rd4(rd[4]),
    .i_data0(data[0]), .i_data1(data[1]),
    .i_data2(data[2]), .i_data3(data[3]),
    .i_data4(data[4]),
    .o_ready0(rdy[0]), .o_ready1(rdy[1]),
    .o_ready2(rdy[2]), .o_ready3(rdy[3]),
    .o_ready4(rdy[4]),
    .o_we0(we0), .o_we1(we1),
    .o_waddr0(wa0), .o_waddr1(wa1),
    .o_wdata0(wd0), .o_wdata1(wd1),
    .o_bypass(byp)
  );

  always @(negedge clk)
    if (!rst)
      assert (!(we0 && we1 && wa0 == wa1 && wa0 != 5'd0))
        else $error("same rd written on both ports: %0d", wa0);

  function automatic logic [31:0] enc(input int m, input int s);
    return (32'(m) << 28) | 32'(s);
  endfunction

  task automatic idle_inputs;
    flush = 1'b0;
    valid = '0;
    for (int k = 0; k < 5; k++) begin
      rd[k]   = '0;
      data[k] = '0;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, we1, wa0, wa1, wd0, wd1, byp} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got we=%b%b wa=%0d/%0d wd=%h/%h byp=%0d want 0",
               we0, we1, wa0, wa1, wd0, wd1, byp);
    end
    n_cmp++;
    if (rdy !== 5'h1f) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 11111", rdy);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    valid[3] = 1'b1; rd[3] = 5'd7; data[3] = 32'hDEADBEEF;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if ({we0, byp} !== 6'd0) begin
      n_bad++;
      $display("FAIL single_early got we0=%b byp=%0d want 0", we0, byp);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, wa0, wd0, byp, we1} !==
        {1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 1'b0}) begin
      n_bad++;
      $display("FAIL single_write got we0=%b wa0=%0d wd0=%h byp=%0d we1=%b want 1/7/deadbeef/7/0",
               we0, wa0, wd0, byp, we1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, we1} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_dup got we=%b%b want 00", we0, we1);
    end
    // rr now points at 4: module 4 must beat module 0.
    valid[0] = 1'b1; rd[0] = 5'd3; data[0] = 32'h100;
    valid[4] = 1'b1; rd[4] = 5'd4; data[4] = 32'h400;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, wa0, wd0, we1, wa1, wd1} !==
        {1'b1, 5'd4, 32'h400, 1'b1, 5'd3, 32'h100}) begin
      n_bad++;
      $display("FAIL rr_after_single got wa0=%0d wd0=%h wa1=%0d wd1=%h want 4/400/3/100",
               wa0, wd0, wa1, wd1);
    end
  endtask

  task automatic test_fairness;
    int seq[5], pop_n[5], cnt[5];
    int m0, m1;
    logic [4:0] acc;
    logic saw_low;
    do_reset();
    saw_low = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seq[k] = 0; pop_n[k] = 0; cnt[k] = 0;
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      for (int k = 0; k < 5; k++) begin
        valid[k] = 1'b1;
        rd[k]    = 5'(k + 1);
        data[k]  = enc(k, seq[k]);
      end
      acc = rdy;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++)
        if (acc[k]) begin
          seq[k]++;
          cnt[k]++;
        end
      if (cyc >= 1) begin
        m0 = (2 * (cyc - 1)) % 5;
        m1 = (2 * (cyc - 1) + 1) % 5;
        cnt[m0]--;
        cnt[m1]--;
        n_cmp++;
        if ({we0, wa0, wd0, byp} !==
            {1'b1, 5'(m0 + 1), enc(m0, pop_n[m0]), 5'(m0 + 1)}) begin
          n_bad++;
          $display("FAIL fair_p0 cyc%0d got we0=%b wa0=%0d wd0=%h byp=%0d want mod %0d seq %0d",
                   cyc, we0, wa0, wd0, byp, m0, pop_n[m0]);
        end
        n_cmp++;
        if ({we1, wa1, wd1} !==
            {1'b1, 5'(m1 + 1), enc(m1, pop_n[m1])}) begin
          n_bad++;
          $display("FAIL fair_p1 cyc%0d got we1=%b wa1=%0d wd1=%h want mod %0d seq %0d",
                   cyc, we1, wa1, wd1, m1, pop_n[m1]);
        end
        pop_n[m0]++;
        pop_n[m1]++;
      end
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (rdy[k] !== (cnt[k] < 2)) begin
          n_bad++;
          $display("FAIL fair_ready cyc%0d mod%0d got %b want %b",
                   cyc, k, rdy[k], cnt[k] < 2);
        end
        if (!rdy[k]) saw_low = 1'b1;
      end
    end
    idle_inputs();
    n_cmp++;
    if (saw_low !== 1'b1) begin
      n_bad++;
      $display("FAIL fair_ready_toggle got no low ready want some");
    end
  endtask

  task automatic test_backpressure;
    int seq[5], pop_n[5], mc[5], g[2];
    int mrr, ng, m;
    logic [4:0] acc;
    do_reset();
    mrr = 0;
    for (int k = 0; k < 5; k++) begin
      seq[k] = 0; pop_n[k] = 0; mc[k] = 0;
    end
    for (int cyc = 0; cyc < 18; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        valid[k] = (cyc < 10);
        rd[k]    = 5'(k + 1);
        data[k]  = enc(k, seq[k]);
      end
      ng = 0; g[0] = 0; g[1] = 0;
      for (int i = 0; i < 5; i++) begin
        m = (mrr + i) % 5;
        if (mc[m] > 0 && ng < 2) begin
          g[ng] = m;
          ng++;
        end
      end
      for (int k = 0; k < 5; k++) begin
        acc[k] = valid[k] & (mc[k] < 2);
        n_cmp++;
        if (rdy[k] !== (mc[k] < 2)) begin
          n_bad++;
          $display("FAIL bp_ready cyc%0d mod%0d got %b count %0d",
                   cyc, k, rdy[k], mc[k]);
        end
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({we0, we1} !== {ng >= 1, ng >= 2}) begin
        n_bad++;
        $display("FAIL bp_we cyc%0d got %b%b want %b%b",
                 cyc, we0, we1, ng >= 1, ng >= 2);
      end
      if (ng >= 1) begin
        n_cmp++;
        if ({wa0, wd0} !== {5'(g[0] + 1), enc(g[0], pop_n[g[0]])}) begin
          n_bad++;
          $display("FAIL bp_p0 cyc%0d got wa0=%0d wd0=%h want mod %0d seq %0d",
                   cyc, wa0, wd0, g[0], pop_n[g[0]]);
        end
        pop_n[g[0]]++;
      end
      if (ng >= 2) begin
        n_cmp++;
        if ({wa1, wd1} !== {5'(g[1] + 1), enc(g[1], pop_n[g[1]])}) begin
          n_bad++;
          $display("FAIL bp_p1 cyc%0d got wa1=%0d wd1=%h want mod %0d seq %0d",
                   cyc, wa1, wd1, g[1], pop_n[g[1]]);
        end
        pop_n[g[1]]++;
      end
      for (int k = 0; k < 5; k++)
        if (acc[k]) begin
          mc[k]++;
          seq[k]++;
        end
      for (int j = 0; j < ng; j++) mc[g[j]]--;
      if (ng > 0) mrr = (g[ng - 1] + 1) % 5;
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (pop_n[k] !== seq[k]) begin
        n_bad++;
        $display("FAIL bp_total mod%0d got %0d written want %0d pushed",
                 k, pop_n[k], seq[k]);
      end
    end
  endtask

  task automatic test_rd0_drop;
    do_reset();
    valid[1] = 1'b1; rd[1] = 5'd0; data[1] = 32'h5;
    @(posedge clk); #1;
    rd[1] = 5'd9; data[1] = 32'h66;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if ({we0, we1, byp} !== 7'd0) begin
      n_bad++;
      $display("FAIL rd0_drop got we=%b%b byp=%0d want 0/0/0", we0, we1, byp);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, wa0, wd0, byp} !== {1'b1, 5'd9, 32'h66, 5'd9}) begin
      n_bad++;
      $display("FAIL rd0_next got we0=%b wa0=%0d wd0=%h byp=%0d want 1/9/66/9",
               we0, wa0, wd0, byp);
    end
  endtask

  task automatic test_flush;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 5; k++) begin
        valid[k] = 1'b1;
        rd[k]    = 5'(k + 1);
        data[k]  = 32'hF000_0000 | 32'(k);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    flush = 1'b1;
    valid[2] = 1'b1; rd[2] = 5'd20; data[2] = 32'hBAD;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if ({we0, we1, byp} !== 7'd0) begin
      n_bad++;
      $display("FAIL flush_we got we=%b%b byp=%0d want 0", we0, we1, byp);
    end
    n_cmp++;
    if (rdy !== 5'h1f) begin
      n_bad++;
      $display("FAIL flush_ready got %b want 11111", rdy);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({we0, we1} !== 2'b00) begin
        n_bad++;
        $display("FAIL flush_leak c%0d got we=%b%b wa=%0d/%0d want 00",
                 c, we0, we1, wa0, wa1);
      end
    end
    // rr back at 0: module 0 must beat module 4.
    valid[0] = 1'b1; rd[0] = 5'd11; data[0] = 32'hA0;
    valid[4] = 1'b1; rd[4] = 5'd14; data[4] = 32'hA4;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, wa0, wd0, we1, wa1, wd1} !==
        {1'b1, 5'd11, 32'hA0, 1'b1, 5'd14, 32'hA4}) begin
      n_bad++;
      $display("FAIL flush_rr got wa0=%0d wd0=%h wa1=%0d wd1=%h want 11/a0/14/a4",
               wa0, wd0, wa1, wd1);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    valid[0] = 1'b1; rd[0] = 5'd1; data[0] = 32'h11;
    valid[1] = 1'b1; rd[1] = 5'd2; data[1] = 32'h22;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({we0, we1} !== 2'b11) begin
      n_bad++;
      $display("FAIL async_pre got we=%b%b want 11", we0, we1);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({we0, we1, wa0, wa1, wd0, wd1, byp} !== '0) begin
      n_bad++;
      $display("FAIL async_outs got we=%b%b wa=%0d/%0d byp=%0d want 0",
               we0, we1, wa0, wa1, byp);
    end
    n_cmp++;
    if (rdy !== 5'h1f) begin
      n_bad++;
      $display("FAIL async_ready got %b want 11111", rdy);
    end
    idle_inputs();
    @(posedge clk);
    #3 rst = 1'b0;
    valid[2] = 1'b1; rd[2] = 5'd9; data[2] = 32'h99;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if (we0 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_early got we0=%b want 0", we0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({we0, wa0, wd0, we1} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
      n_bad++;
      $display("FAIL async_after got we0=%b wa0=%0d wd0=%h we1=%b want 1/9/99/0",
               we0, wa0, wd0, we1);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_rd0_drop();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
